// File: rtl/magnitude_comparator_seq_pkg.sv
// magnitude_comparator_seq_pkg: shared state encoding and nibble constants for the sequential comparator
package magnitude_comparator_seq_pkg;
    localparam int NIBBLE = 4;
    typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_e;
    function automatic int idx_width(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction
endpackage

// File: rtl/magnitude_comparator.sv
// magnitude_comparator: 4-bit combinational unsigned magnitude comparator
module magnitude_comparator
    import magnitude_comparator_seq_pkg::*;
(
    input  logic [NIBBLE-1:0] A,
    input  logic [NIBBLE-1:0] B,
    output logic              X,
    output logic              Y,
    output logic              Z
);
    assign X = A > B;
    assign Y = A == B;
    assign Z = A < B;
endmodule

// File: rtl/magnitude_comparator_seq.sv
// magnitude_comparator_seq: wide magnitude compare, one nibble per cycle from the MSB down
module magnitude_comparator_seq
    import magnitude_comparator_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);
    localparam int NIBBLES = WIDTH / NIBBLE;
    localparam int IW = idx_width(NIBBLES);

    if (WIDTH % NIBBLE != 0 || WIDTH < NIBBLE) begin : g_bad_width
        $error("magnitude_comparator_seq: WIDTH must be a positive multiple of 4");
    end

    state_e          state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            busy_q, busy_d, done_q, done_d;
    logic            gt_q, gt_d, eq_q, eq_d, lt_q, lt_d;
    logic [NIBBLE-1:0] a_nib, b_nib;
    logic            n_gt, n_eq, n_lt;

    assign a_nib = NIBBLE'(a_q >> {idx_q, 2'b00});
    assign b_nib = NIBBLE'(b_q >> {idx_q, 2'b00});

    magnitude_comparator u_cmp (
        .A(a_nib),
        .B(b_nib),
        .X(n_gt),
        .Y(n_eq),
        .Z(n_lt)
    );

    // next state: latch on start, walk nibbles down, stop at first difference or nibble 0
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        gt_d    = gt_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = COMPARE;
                a_d     = a;
                b_d     = b;
                idx_d   = IW'(NIBBLES - 1);
                gt_d    = 1'b0;
                eq_d    = 1'b0;
                lt_d    = 1'b0;
            end
            COMPARE: if (!n_eq || idx_q == '0) begin
                state_d = DONE;
                gt_d    = n_gt;
                eq_d    = n_eq;
                lt_d    = n_lt;
            end else begin
                idx_d = idx_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
        done_d = state_d == DONE;
    end

    // state and registered outputs; operands and index need no reset
    always_ff @(posedge clk) begin
        a_q   <= a_d;
        b_q   <= b_d;
        idx_q <= idx_d;
        if (!rst_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign gt   = gt_q;
    assign eq   = eq_q;
    assign lt   = lt_q;
endmodule

// File: tb/tb_magnitude_comparator_seq.sv
// tb_magnitude_comparator_seq: scoreboard bench with directed vectors for magnitude_comparator_seq
module tb_magnitude_comparator_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        busy, done, gt, eq, lt;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [2:0] res;
        int         cyc;
    } exp_t;
    exp_t sb[$];

    magnitude_comparator_seq #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .gt(gt), .eq(eq), .lt(lt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: every done pulse must match the oldest expected result and cycle
    always @(negedge clk) begin
        if (done) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL spurious_done: done at cycle %0d with gt/eq/lt=%b, none expected", cyc, {gt, eq, lt});
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({gt, eq, lt} !== e.res || cyc != e.cyc || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL result: got gt/eq/lt=%b cyc=%0d busy=%b expected %b cyc=%0d busy=1",
                             {gt, eq, lt}, cyc, busy, e.res, e.cyc);
                end
            end
        end
    end

    // start accepted at the next edge; lat is the cycle of done counting the accept cycle as 0
    task automatic issue(input logic [15:0] av, input logic [15:0] bv, input logic [2:0] res,
                         input int lat, input bit push);
        start = 1'b1;
        a = av;
        b = bv;
        @(posedge clk);
        #1 start = 1'b0;
        if (push) sb.push_back('{res, cyc + lat - 1});
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: %0d results never arrived", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_res", {gt, eq, lt}, 3'b000);
        start = 1'b1;
        a = 16'h0001;
        @(posedge clk);
        #1 start = 1'b0;
        check("start_in_reset", {busy, done, gt, eq, lt}, 5'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // test 1: all nibbles equal, busy cycles 1-5
        issue(16'h1234, 16'h1234, 3'b010, 5, 1);
        for (int i = 1; i <= 5; i++) begin
            check($sformatf("t1_busy_c%0d", i), busy, 1);
            @(posedge clk);
            #1;
        end
        check("t1_busy_c6", busy, 0);
        wait_empty();
        // test 2: decided on MSB nibble, result holds afterwards
        issue(16'h8000, 16'h7FFF, 3'b100, 2, 1);
        wait_empty();
        repeat (3) @(posedge clk);
        #1 check("t2_hold", {busy, gt, eq, lt}, 4'b0100);
        // test 3: decided on third nibble
        issue(16'h12A4, 16'h12B4, 3'b001, 4, 1);
        wait_empty();
        // test 4: start while busy is ignored
        issue(16'h0001, 16'h0002, 3'b001, 5, 1);
        @(posedge clk);
        #1;
        start = 1'b1;
        a = 16'hFFFF;
        b = 16'h0000;
        @(posedge clk);
        #1 start = 1'b0;
        wait_empty();
        repeat (6) @(posedge clk);
        #1;
        // test 5: reset mid-operation discards the result
        issue(16'hF000, 16'hF001, 3'b001, 5, 0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("t5_after_rst", {busy, done, gt, eq, lt}, 5'b0);
        repeat (6) @(posedge clk);
        #1 check("t5_no_done", {busy, done}, 2'b00);
        issue(16'h0003, 16'h0002, 3'b100, 5, 1);
        wait_empty();
        // test 6: operand change after acceptance has no effect
        issue(16'h5555, 16'h5556, 3'b001, 5, 1);
        a = 16'hFFFF;
        wait_empty();
        repeat (5) @(posedge clk);
        #1 check("final_idle", {busy, done, gt, eq, lt}, 5'b00001);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/magnitude_comparator_seq.md
Name: magnitude_comparator_seq

Overview:
Sequential wide-operand magnitude comparator controller. It time-multiplexes a single 4-bit combinational magnitude comparator across the nibbles of two WIDTH-bit operands. Comparison runs from the MSB nibble down and stops at the first unequal nibble. The block exposes a start/busy/done handshake with registered gt/eq/lt results, and sits between a requesting datapath and the shared 4-bit comparator datapath.

Parameters:
WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4.
NIBBLES, WIDTH/4, derived localparam; number of compare steps, not overridable.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
start  input  1  request pulse; sampled only in IDLE
a  input  WIDTH  operand A; latched when start is accepted
b  input  WIDTH  operand B; latched when start is accepted
busy  output  1  high from the cycle after start is accepted through the DONE cycle inclusive
done  output  1  one-cycle pulse; results are valid from this cycle
gt  output  1  A > B (unsigned)
eq  output  1  A == B
lt  output  1  A < B (unsigned)

Behaviour:
- Clocking and reset: one clock. Reset is synchronous, active-low on rst_n.
- Reset state: IDLE. busy, done, gt, eq and lt are all 0. The operand registers and nibble index are don't-care.
- States:
  - IDLE -> COMPARE when start=1. In that cycle, latch a_r=a, b_r=b, set idx=NIBBLES-1, and clear gt/eq/lt to 0.
  - COMPARE: the comparator sees a_r[4*idx+3:4*idx] and b_r[4*idx+3:4*idx].
    - Nibble greater: set gt=1, go to DONE.
    - Nibble less: set lt=1, go to DONE.
    - Nibble equal and idx==0: set eq=1, go to DONE.
    - Nibble equal and idx>0: decrement idx, stay in COMPARE.
  - DONE: done=1 for exactly one cycle, then -> IDLE unconditionally.
- Latency: start accepted at cycle 0. The deciding compare happens at cycle k, where k is the number of nibbles examined (1..NIBBLES). done is asserted at cycle k+1. The worst case is NIBBLES+1 cycles.
- Results: gt/eq/lt are registered and at most one is high. They hold until the next accepted start, which clears them.
- Handshake: start while busy (COMPARE or DONE) is ignored; no queuing. Changes on a/b after acceptance have no effect.
- Simultaneous events: reset has priority over everything. If start and rst_n=0 occur in the same cycle, the block stays in IDLE with all outputs 0.
- Reset mid-operation: the next cycle is IDLE, the in-flight result is discarded, and no done pulse is generated.
- idx register width: max(1, clog2(NIBBLES)). With WIDTH=4 the block decides in one compare cycle.
- WIDTH not a multiple of 4 is unsupported; elaboration fails with an error.

Decomposition:
- Shared package/header: state encodings (IDLE, COMPARE, DONE) and the NIBBLE constant 4.
- Sub-module: one instance of the existing 4-bit combinational magnitude_comparator (inputs A, B; outputs X=A>B, Y=A==B, Z=A<B), driven by the selected nibble.
- FSM, index counter and result registers live in magnitude_comparator_seq itself.

Test Plan:
1. WIDTH=16, start with a=0x1234, b=0x1234 -> four compare cycles; done at cycle 5; eq=1, gt=lt=0; busy high cycles 1-5.
2. a=0x8000, b=0x7FFF -> decided on the MSB nibble; done at cycle 2; gt=1.
3. a=0x12A4, b=0x12B4 -> nibbles 1 and 2 are equal, A<B on nibble 3; done at cycle 4; lt=1.
4. Start a=0x0001, b=0x0002; at cycle 2 pulse start with a=0xFFFF, b=0x0000 -> second start ignored; done at cycle 5 with lt=1; no second done.
5. Start a=0xF000, b=0xF001; drive rst_n=0 at cycle 2 -> cycle 3 is IDLE with all outputs 0, no done. A new start with a=0x0003, b=0x0002 gives done at cycle 5 relative to that start, gt=1.
6. Start a=0x5555, b=0x5556, then change a to 0xFFFF in cycle 1 -> the result uses latched values: lt=1, done at cycle 5.
